// File: rtl/btn_debounce_pkg.sv
// Shared board timing defaults for button conditioning.
// Every btn_debounce instance picks these up unless overridden.
package btn_debounce_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_EN_DEF       = 1;
  localparam int REPEAT_DELAY_DEF    = 64;
  localparam int REPEAT_PERIOD_DEF   = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_sync_chain.sv
// N-flop synchronizer with synchronous reset.
// Reusable for any asynchronous single-bit input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: sync, debounce, press/repeat and release strobes.
// Outputs are registered; the FSM sees only the synchronized sample.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_EN       = REPEAT_EN_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   dcnt;
  logic [RW-1:0]   rcnt;
  logic            rep;
  logic            s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  // rcnt restarts from 0 on every repeat; rep selects delay vs period target
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dcnt        <= '0;
      rcnt        <= '0;
      rep         <= 1'b0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state     <= HELD;
              btn_level <= 1'b1;
              btn_pulse <= 1'b1;
              rcnt      <= '0;
              rep       <= 1'b0;
            end else begin
              state <= DB_PRESS;
              dcnt  <= D_ONE;
            end
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state     <= HELD;
            dcnt      <= '0;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
            rcnt      <= '0;
            rep       <= 1'b0;
          end else begin
            dcnt <= dcnt + D_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state       <= IDLE;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end else begin
              state <= DB_RELEASE;
              dcnt  <= D_ONE;
            end
          end else if (REPEAT_EN != 0) begin
            if (rcnt == (rep ? R_NEXT : R_FIRST)) begin
              btn_pulse <= 1'b1;
              rcnt      <= '0;
              rep       <= 1'b1;
            end else begin
              rcnt <= rcnt + R_ONE;
            end
          end
        end
        DB_RELEASE: begin
          if (s) begin
            state <= HELD;
            dcnt  <= '0;
            rcnt  <= '0;
            rep   <= 1'b0;
          end else if (dcnt == D_LAST) begin
            state       <= IDLE;
            dcnt        <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            dcnt <= dcnt + D_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: defaults, no-repeat and
// single-cycle-debounce instances with strobe timing checks.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_f = 1'b0;

  logic d_level, d_pulse, d_rel;
  logic n_level, n_pulse, n_rel;
  logic f_level, f_pulse, f_rel;

  int cyc = 0;
  int c = 0;
  int checks = 0;
  int fails = 0;
  int excl_bad = 0;

  int pq[$];
  int rq[$];
  int nq[$];
  int nrq[$];
  int fq[$];
  int frq[$];

  always #5 clk = ~clk;

  btn_debounce u_dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (d_level),
    .btn_pulse   (d_pulse),
    .btn_release (d_rel)
  );

  btn_debounce #(
    .REPEAT_EN (0)
  ) u_norep (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (n_level),
    .btn_pulse   (n_pulse),
    .btn_release (n_rel)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (1)
  ) u_fast (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_f),
    .btn_level   (f_level),
    .btn_pulse   (f_pulse),
    .btn_release (f_rel)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // record strobe cycles on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (d_pulse) pq.push_back(cyc);
    if (d_rel)   rq.push_back(cyc);
    if (n_pulse) nq.push_back(cyc);
    if (n_rel)   nrq.push_back(cyc);
    if (f_pulse) fq.push_back(cyc);
    if (f_rel)   frq.push_back(cyc);
    if ((d_pulse && d_rel) || (n_pulse && n_rel) || (f_pulse && f_rel))
      excl_bad <= excl_bad + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i, input int base);
    return (q.size() > i) ? q[i] - base - 1 : -1;
  endfunction

  task automatic clr();
    pq.delete(); rq.delete(); nq.delete();
    nrq.delete(); fq.delete(); frq.delete();
  endtask

  initial begin
    tick(3);
    chk("reset_level",   int'(d_level), 0);
    chk("reset_pulse",   int'(d_pulse), 0);
    chk("reset_release", int'(d_rel),   0);
    reset = 1'b0;
    tick(2);
    clr();

    // clean press
    btn_in = 1'b1;
    c = cyc;
    tick(40);
    chk("press_count",   pq.size(), 1);
    chk("press_edge",    at(pq, 0, c), 17);
    chk("press_level",   int'(d_level), 1);
    chk("press_norel",   rq.size(), 0);
    chk("norep_edge",    at(nq, 0, c), 17);

    // auto-repeat over 200 held cycles
    tick(160);
    chk("rep_count",     pq.size(), 9);
    chk("rep_first",     at(pq, 1, c), 81);
    chk("rep_second",    at(pq, 2, c), 97);
    chk("rep_third",     at(pq, 3, c), 113);
    chk("rep_last",      at(pq, 8, c), 193);
    chk("norep_count",   nq.size(), 1);

    // short release glitch restarts the repeat delay
    clr();
    c = cyc;
    btn_in = 1'b0;
    tick(5);
    btn_in = 1'b1;
    tick(75);
    chk("glitch_count",  pq.size(), 1);
    chk("glitch_rep",    at(pq, 0, c), 71);
    chk("glitch_level",  int'(d_level), 1);
    chk("glitch_norel",  rq.size(), 0);

    // release bounce: 10 low, 3 high, then low
    clr();
    c = cyc;
    btn_in = 1'b0;
    tick(10);
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    tick(22);
    chk("rel_no_pulse",  pq.size(), 0);
    chk("rel_count",     rq.size(), 1);
    chk("rel_edge",      at(rq, 0, c), 30);
    chk("rel_level",     int'(d_level), 0);
    chk("norep_rel",     at(nrq, 0, c), 30);

    // press bounce: 1,0,1,0 runs of 5, then steady high
    clr();
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      btn_in = (i % 2 == 0);
      tick(5);
    end
    btn_in = 1'b1;
    tick(25);
    chk("bounce_count",  pq.size(), 1);
    chk("bounce_edge",   at(pq, 0, c), 37);
    chk("bounce_norel",  rq.size(), 0);

    // reset in the middle of a held press
    clr();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_level",     int'(d_level), 0);
    chk("rst_pulse",     int'(d_pulse), 0);
    c = cyc;
    tick(25);
    chk("rst_repress",   at(pq, 0, c), 17);
    chk("rst_count",     pq.size(), 1);
    chk("rst_norel",     rq.size(), 0);
    chk("rst_level_up",  int'(d_level), 1);

    // single-cycle debounce instance
    clr();
    c = cyc;
    btn_f = 1'b1;
    tick(5);
    chk("fast_press",    at(fq, 0, c), 2);
    chk("fast_level",    int'(f_level), 1);
    c = cyc;
    btn_f = 1'b0;
    tick(5);
    chk("fast_release",  at(frq, 0, c), 2);
    chk("fast_low",      int'(f_level), 0);
    chk("fast_pcount",   fq.size(), 1);

    chk("strobe_excl",   excl_bad, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
